// File: rtl/ariane_pkg.sv
// Shared core types: FU selector, operation codes, branch-prediction tag and
// the dispatch-register payload bundle.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6
  } fu_t;

  typedef enum logic [3:0] {
    ADD, SUB, ANDL, ORL, MUL, LD, SD, EQ, CSR_READ
  } fu_op;

  typedef enum logic [1:0] {
    NO_CF, BRANCH, JUMP, RETURN
  } cf_t;

  typedef struct packed {
    logic [63:0] predict_address;
    cf_t         cf;
  } branchpredict_sbe_t;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     is_compressed_instr;
    branchpredict_sbe_t       branch_predict;
  } dispatch_entry_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/fu_dispatch_inflight_counter.sv
// In-flight instruction counter: +1 per dispatch, minus the number of
// writeback strobes, floored at zero, cleared by flush.
module inflight_counter #(
  parameter  int unsigned NR_SB_ENTRIES = 8,
  localparam int unsigned CNT_W         = $clog2(NR_SB_ENTRIES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [5:0]       wb_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             space_o
);

  localparam int unsigned SUM_W = CNT_W + 3;

  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] wb_cnt;
  logic [SUM_W-1:0] up;
  logic [SUM_W-1:0] cur;

  always_comb begin
    wb_cnt = '0;
    for (int i = 0; i < 6; i++) wb_cnt = wb_cnt + SUM_W'(wb_i[i]);
    cur = SUM_W'(cnt_q);
    up  = cur + SUM_W'(inc_i);
  end

  // Writebacks in the current cycle free capacity for a same-cycle dispatch.
  assign space_o = cur < (SUM_W'(NR_SB_ENTRIES) + wb_cnt);
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            cnt_q <= '0;
    else if (clear_i)     cnt_q <= '0;
    else if (up < wb_cnt) cnt_q <= '0;
    else                  cnt_q <= CNT_W'(up - wb_cnt);
  end

  always @(posedge clk_i) begin
    if (!rst_i && !clear_i) assert (up >= wb_cnt);
  end

endmodule

// File: rtl/fu_dispatch.sv
// One-entry dispatch register steering issued instructions to execute FUs.
// Optional FU_DISPATCH_STATS_EN adds a saturating stall_cycles_o counter.
module fu_dispatch
  import ariane_pkg::*;
#(
  parameter  int unsigned NR_SB_ENTRIES = 8,
  localparam int unsigned CNT_W         = $clog2(NR_SB_ENTRIES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  fu_t                      fu_i,
  input  fu_op                     operator_i,
  input  logic [63:0]              operand_a_i,
  input  logic [63:0]              operand_b_i,
  input  logic [63:0]              imm_i,
  input  logic [63:0]              pc_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic                     is_compressed_instr_i,
  input  branchpredict_sbe_t       branch_predict_i,
  output fu_t                      fu_o,
  output fu_op                     operator_o,
  output logic [63:0]              operand_a_o,
  output logic [63:0]              operand_b_o,
  output logic [63:0]              imm_o,
  output logic [63:0]              pc_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     is_compressed_instr_o,
  output branchpredict_sbe_t       branch_predict_o,
  input  logic                     alu_ready_i,
  input  logic                     branch_ready_i,
  input  logic                     lsu_ready_i,
  input  logic                     csr_ready_i,
  input  logic                     mult_ready_i,
  output logic                     alu_valid_o,
  output logic                     branch_valid_o,
  output logic                     lsu_valid_o,
  output logic                     csr_valid_o,
  output logic                     mult_valid_o,
  input  logic                     alu_wb_i,
  input  logic                     branch_wb_i,
  input  logic                     ld_wb_i,
  input  logic                     st_wb_i,
  input  logic                     csr_wb_i,
  input  logic                     mult_wb_i,
  input  logic                     resolve_branch_i,
`ifdef FU_DISPATCH_STATS_EN
  output logic [31:0]              stall_cycles_o,
`endif
  output logic [CNT_W-1:0]         inflight_o
);

  disp_state_e     state_q, state_d;
  dispatch_entry_t entry_q;
  logic            branch_pending_q;
  logic            tgt_ready;
  logic            space;
  logic            dispatch;
  logic            retire_none;
  logic            accept;

  always_comb begin
    state_d       = state_q;
    tgt_ready     = 1'b0;
    dispatch      = 1'b0;
    retire_none   = 1'b0;
    issue_ready_o = 1'b0;
    accept        = 1'b0;
    unique case (entry_q.fu)
      ALU:         tgt_ready = alu_ready_i;
      CTRL_FLOW:   tgt_ready = branch_ready_i;
      LOAD, STORE: tgt_ready = lsu_ready_i;
      CSR:         tgt_ready = csr_ready_i;
      MULT:        tgt_ready = mult_ready_i;
      default:     tgt_ready = 1'b0;
    endcase
    if (state_q == FULL && !flush_i) begin
      if (entry_q.fu == NONE) retire_none = 1'b1;
      else dispatch = tgt_ready && space &&
                      !(entry_q.fu == CTRL_FLOW && branch_pending_q);
    end
    issue_ready_o = !flush_i && (state_q == EMPTY || dispatch || retire_none);
    accept        = issue_valid_i && issue_ready_o;
    if (flush_i)                       state_d = EMPTY;
    else if (accept)                   state_d = FULL;
    else if (dispatch || retire_none)  state_d = EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= EMPTY;
      entry_q          <= '0;
      branch_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        entry_q.fu                  <= fu_i;
        entry_q.operator            <= operator_i;
        entry_q.operand_a           <= operand_a_i;
        entry_q.operand_b           <= operand_b_i;
        entry_q.imm                 <= imm_i;
        entry_q.pc                  <= pc_i;
        entry_q.trans_id            <= trans_id_i;
        entry_q.is_compressed_instr <= is_compressed_instr_i;
        entry_q.branch_predict      <= branch_predict_i;
      end
      // A new branch dispatched in the resolve cycle keeps the flag set.
      if (flush_i)                                    branch_pending_q <= 1'b0;
      else if (dispatch && entry_q.fu == CTRL_FLOW)   branch_pending_q <= 1'b1;
      else if (resolve_branch_i)                      branch_pending_q <= 1'b0;
    end
  end

  inflight_counter #(
    .NR_SB_ENTRIES(NR_SB_ENTRIES)
  ) i_inflight (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(flush_i),
    .inc_i  (dispatch),
    .wb_i   ({alu_wb_i, branch_wb_i, ld_wb_i, st_wb_i, csr_wb_i, mult_wb_i}),
    .cnt_o  (inflight_o),
    .space_o(space)
  );

  assign alu_valid_o    = dispatch && entry_q.fu == ALU;
  assign branch_valid_o = dispatch && entry_q.fu == CTRL_FLOW;
  assign lsu_valid_o    = dispatch && (entry_q.fu == LOAD || entry_q.fu == STORE);
  assign csr_valid_o    = dispatch && entry_q.fu == CSR;
  assign mult_valid_o   = dispatch && entry_q.fu == MULT;

  assign fu_o                  = entry_q.fu;
  assign operator_o            = entry_q.operator;
  assign operand_a_o           = entry_q.operand_a;
  assign operand_b_o           = entry_q.operand_b;
  assign imm_o                 = entry_q.imm;
  assign pc_o                  = entry_q.pc;
  assign trans_id_o            = entry_q.trans_id;
  assign is_compressed_instr_o = entry_q.is_compressed_instr;
  assign branch_predict_o      = entry_q.branch_predict;

`ifdef FU_DISPATCH_STATS_EN
  // Survives flush on purpose: it measures lifetime back-pressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cycles_o <= '0;
    else if (state_q == FULL && !dispatch && stall_cycles_o != 32'hFFFF_FFFF)
      stall_cycles_o <= stall_cycles_o + 32'd1;
  end
`endif

endmodule
